// File: rtl/multdiv_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// multdiv_issue_ctrl_if
//   Bundles every non-clock/reset signal of multdiv_issue_ctrl.
//   Signal groups:
//     issue_*      execute stage -> controller: mult/div request and operands
//     flush        pipeline flush, aborts an op in flight
//     md_*         controller <-> multdiv unit: operands, start pulses, result
//     stall        controller -> pipeline: freeze upstream stages
//     wb_*         controller -> regfile writeback port, valid/ready handshake
//   Modports:
//     slave   the controller's view (consumes issue/md results, drives md/wb)
//     master  the environment's view (pipeline, multdiv and regfile side)
// -----------------------------------------------------------------------------
interface multdiv_issue_ctrl_if;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_opA;
  logic [31:0] issue_opB;
  logic [4:0]  issue_rd;
  logic        flush;

  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  modport slave (
    input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
    input  md_result, md_exception, md_resultRDY, wb_ready,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data
  );

  modport master (
    output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
    output md_result, md_exception, md_resultRDY, wb_ready,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_issue_ctrl
//   Pipeline-side controller in front of a multi-cycle multdiv unit. Accepts a
//   mult/div op, latches operands, fires a one-cycle start pulse, stalls the
//   pipeline until the unit reports ready (or a watchdog expires), then offers
//   the result -- or an exception code aimed at the status register -- on a
//   valid/ready writeback port. Handles flush abort of an op in flight.
//   Ports:
//     clock   rising-edge system clock
//     reset   asynchronous, active-high; returns to IDLE with all outputs 0
//     bus     multdiv_issue_ctrl_if.slave (issue, multdiv, stall, writeback)
//   Parameters:
//     MAX_CYCLES     WAIT cycles without ready before a forced timeout
//     RSTATUS_REG    destination register for exception/timeout codes
//     MULT_EXC_CODE  code written on mult exception/timeout
//     DIV_EXC_CODE   code written on div exception/timeout
// -----------------------------------------------------------------------------
module multdiv_issue_ctrl #(
  parameter int unsigned MAX_CYCLES    = 40,
  parameter int unsigned RSTATUS_REG   = 30,
  parameter int unsigned MULT_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE  = 5
) (
  input logic                 clock,
  input logic                 reset,
  multdiv_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB
  } state_e;

  localparam int unsigned         CNT_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [4:0]          EXC_RD   = 5'(RSTATUS_REG);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic              is_div_q, is_div_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [31:0]       exc_code;

  assign exc_code = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    is_div_d  = is_div_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;

    unique case (state_q)
      S_IDLE: begin
        // Flush beats a same-cycle issue; a late md_resultRDY here is ignored.
        if (bus.issue_valid && !bus.flush) begin
          op_a_d   = bus.issue_opA;
          op_b_d   = bus.issue_opB;
          is_div_d = bus.issue_is_div;
          rd_d     = bus.issue_rd;
          state_d  = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = bus.flush ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.md_resultRDY) begin
          if (bus.md_exception) begin
            wb_rd_d   = EXC_RD;
            wb_data_d = exc_code;
            state_d   = S_WB;
          end else if (rd_q == 5'd0) begin
            // Writes to r0 are discarded anyway, so skip the writeback slot.
            state_d = S_IDLE;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = bus.md_result;
            state_d   = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog: the unit never answered, report it as an exception.
          wb_rd_d   = EXC_RD;
          wb_data_d = exc_code;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        // The op is committed here, so flush has no effect.
        if (bus.wb_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand and writeback registers are reset along with the FSM because
  // they drive output ports directly and must read 0 while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      is_div_q  <= 1'b0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      is_div_q  <= is_div_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // All outputs are straight decodes of registered state, so they are
  // glitch-free toward the multdiv unit and the pipeline.
  assign bus.md_operandA  = op_a_q;
  assign bus.md_operandB  = op_b_q;
  assign bus.md_ctrl_MULT = (state_q == S_START) && !is_div_q;
  assign bus.md_ctrl_DIV  = (state_q == S_START) &&  is_div_q;
  assign bus.stall        = (state_q != S_IDLE);
  assign bus.wb_valid     = (state_q == S_WB);
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue_ctrl
//   Directed bench for multdiv_issue_ctrl. Inputs change 1 time unit after the
//   rising edge and outputs are sampled at the same point, so every sample
//   sees the state left by the preceding edge. The bench plays the roles of
//   execute stage, multdiv unit and regfile port.
// -----------------------------------------------------------------------------
module tb_multdiv_issue_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multdiv_issue_ctrl_if bus ();

  multdiv_issue_ctrl #(
    .MAX_CYCLES   (40),
    .RSTATUS_REG  (30),
    .MULT_EXC_CODE(4),
    .DIV_EXC_CODE (5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;

  // Advance one cycle; count start pulses seen in the new cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) pulse_cnt++;
  endtask

  task automatic clear_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_opA    = '0;
    bus.issue_opB    = '0;
    bus.issue_rd     = '0;
    bus.flush        = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.wb_ready     = 1'b0;
  endtask

  // Issue in the current (idle) cycle; returns in the START cycle.
  task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag);
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = is_div;
    bus.issue_opA    = a;
    bus.issue_opB    = b;
    bus.issue_rd     = rd;
    tick();
    bus.issue_valid  = 1'b0;
    bus.issue_opA    = 32'h5A5A_5A5A;
    bus.issue_opB    = 32'hA5A5_A5A5;
    vectors++;
    if (bus.md_ctrl_MULT !== !is_div || bus.md_ctrl_DIV !== is_div) begin
      miscompares++;
      $display("FAIL %s start_pulse: got mult=%b div=%b want mult=%b div=%b",
               tag, bus.md_ctrl_MULT, bus.md_ctrl_DIV, !is_div, is_div);
    end
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL %s stall_start: got %b want 1", tag, bus.stall);
    end
    vectors++;
    if (bus.md_operandA !== a || bus.md_operandB !== b) begin
      miscompares++;
      $display("FAIL %s operands: got %h/%h want %h/%h", tag, bus.md_operandA, bus.md_operandB, a, b);
    end
  endtask

  // Called in the START cycle; md_resultRDY is raised in WAIT cycle n (n>=1).
  task automatic wait_rdy(input int n, input logic [31:0] res, input logic exc, input string tag);
    tick();
    for (int i = 1; i < n; i++) begin
      vectors++;
      if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b1) begin
        miscompares++;
        $display("FAIL %s wait_cycle%0d: got wb_valid=%b stall=%b want 0/1", tag, i, bus.wb_valid, bus.stall);
      end
      tick();
    end
    bus.md_resultRDY = 1'b1;
    bus.md_result    = res;
    bus.md_exception = exc;
    tick();
    bus.md_resultRDY = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = 32'hDEAD_BEEF;
  endtask

  // Called in the first WB cycle; wb_ready held low for 'hold' cycles.
  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input int hold,
                           input logic flush_in_wb, input string tag);
    for (int h = 0; h <= hold; h++) begin
      vectors++;
      if (bus.wb_valid !== 1'b1 || bus.stall !== 1'b1) begin
        miscompares++;
        $display("FAIL %s wb_valid_stall[%0d]: got %b/%b want 1/1", tag, h, bus.wb_valid, bus.stall);
      end
      vectors++;
      if (bus.wb_rd !== rd) begin
        miscompares++;
        $display("FAIL %s wb_rd[%0d]: got %0d want %0d", tag, h, bus.wb_rd, rd);
      end
      vectors++;
      if (bus.wb_data !== data) begin
        miscompares++;
        $display("FAIL %s wb_data[%0d]: got %h want %h", tag, h, bus.wb_data, data);
      end
      bus.wb_ready = (h == hold);
      bus.flush    = flush_in_wb && (h == 0);
      tick();
    end
    bus.wb_ready = 1'b0;
    bus.flush    = 1'b0;
    vectors++;
    if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_wb: got stall=%b wb_valid=%b want 0/0", tag, bus.stall, bus.wb_valid);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    tick();
    tick();
    vectors++;
    if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0 || bus.md_ctrl_MULT !== 1'b0 || bus.md_ctrl_DIV !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ctrl: got stall=%b wb_valid=%b mult=%b div=%b want 0", bus.stall, bus.wb_valid,
               bus.md_ctrl_MULT, bus.md_ctrl_DIV);
    end
    vectors++;
    if (bus.md_operandA !== 32'd0 || bus.md_operandB !== 32'd0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset data: got %h %h %0d %h want 0", bus.md_operandA, bus.md_operandB, bus.wb_rd, bus.wb_data);
    end
    bus.issue_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult_basic();
    pulse_cnt = 0;
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd8, "mult_basic");
    wait_rdy(32, 32'hFFFF_FFEB, 1'b0, "mult_basic");
    expect_wb(5'd8, 32'hFFFF_FFEB, 0, 1'b0, "mult_basic");
    vectors++;
    if (pulse_cnt !== 1) begin
      miscompares++;
      $display("FAIL mult_basic pulse_count: got %0d want 1", pulse_cnt);
    end
  endtask

  // Issued in the very cycle stall first drops; RDY in the first WAIT cycle.
  task automatic test_back_to_back();
    issue(1'b1, 32'd100, 32'd7, 5'd3, "back_to_back");
    wait_rdy(1, 32'd14, 1'b0, "back_to_back");
    expect_wb(5'd3, 32'd14, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_mult_exception();
    issue(1'b0, 32'h4000_0000, 32'd4, 5'd12, "mult_exc");
    wait_rdy(5, 32'd0, 1'b1, "mult_exc");
    expect_wb(5'd30, 32'd4, 0, 1'b0, "mult_exc");
  endtask

  task automatic test_div_exception();
    issue(1'b1, 32'd100, 32'd0, 5'd9, "div_exc");
    wait_rdy(3, 32'hFFFF_FFFF, 1'b1, "div_exc");
    expect_wb(5'd30, 32'd5, 0, 1'b0, "div_exc");
  endtask

  // No RDY at all: WB must appear right after the 40th WAIT cycle, not earlier.
  task automatic test_timeout(input logic is_div, input logic [31:0] code, input string tag);
    issue(is_div, 32'd50, 32'd5, 5'd7, tag);
    tick();
    for (int k = 1; k <= 40; k++) begin
      vectors++;
      if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b1) begin
        miscompares++;
        $display("FAIL %s wait_cycle%0d: got wb_valid=%b stall=%b want 0/1", tag, k, bus.wb_valid, bus.stall);
      end
      tick();
    end
    expect_wb(5'd30, code, 0, 1'b0, tag);
  endtask

  task automatic test_flush_wait();
    int pulses_before;
    issue(1'b0, 32'd3, 32'd4, 5'd6, "flush_wait");
    pulses_before = pulse_cnt;
    tick();
    for (int k = 1; k < 5; k++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    vectors++;
    if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_wait after_flush: got stall=%b wb_valid=%b want 0/0", bus.stall, bus.wb_valid);
    end
    for (int k = 6; k < 10; k++) tick();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'd12;
    tick();
    bus.md_resultRDY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_wait late_rdy[%0d]: got stall=%b wb_valid=%b want 0/0", k, bus.stall, bus.wb_valid);
      end
      tick();
    end
    vectors++;
    if (pulse_cnt !== pulses_before) begin
      miscompares++;
      $display("FAIL flush_wait extra_pulse: got %0d want %0d", pulse_cnt, pulses_before);
    end
  endtask

  task automatic test_flush_start();
    issue(1'b1, 32'd8, 32'd2, 5'd5, "flush_start");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start stall: got %b want 0", bus.stall);
    end
    tick();
    vectors++;
    if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start idle: got wb_valid=%b stall=%b want 0/0", bus.wb_valid, bus.stall);
    end
  endtask

  task automatic test_flush_issue();
    int pulses_before;
    pulses_before    = pulse_cnt;
    bus.issue_valid  = 1'b1;
    bus.issue_opA    = 32'd1;
    bus.issue_rd     = 5'd2;
    bus.flush        = 1'b1;
    tick();
    bus.issue_valid  = 1'b0;
    bus.flush        = 1'b0;
    vectors++;
    if (bus.stall !== 1'b0 || pulse_cnt !== pulses_before) begin
      miscompares++;
      $display("FAIL flush_issue: got stall=%b pulses=%0d want 0/%0d", bus.stall, pulse_cnt, pulses_before);
    end
  endtask

  // wb_ready low for 3 WB cycles, with a flush in the first one.
  task automatic test_wb_hold();
    issue(1'b0, 32'd2, 32'd3, 5'd20, "wb_hold");
    wait_rdy(4, 32'd6, 1'b0, "wb_hold");
    expect_wb(5'd20, 32'd6, 3, 1'b1, "wb_hold");
  endtask

  task automatic test_reset_mid_wait();
    issue(1'b1, 32'd9, 32'd3, 5'd4, "reset_mid");
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0 || bus.md_ctrl_MULT !== 1'b0 || bus.md_ctrl_DIV !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid ctrl: got stall=%b wb_valid=%b mult=%b div=%b want 0", bus.stall, bus.wb_valid,
               bus.md_ctrl_MULT, bus.md_ctrl_DIV);
    end
    vectors++;
    if (bus.md_operandA !== 32'd0 || bus.md_operandB !== 32'd0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid data: got %h %h %0d %h want 0", bus.md_operandA, bus.md_operandB, bus.wb_rd, bus.wb_data);
    end
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid after_release: got stall=%b want 0", bus.stall);
    end
  endtask

  task automatic test_rd_zero();
    issue(1'b0, 32'd5, 32'd6, 5'd0, "rd_zero");
    wait_rdy(2, 32'd30, 1'b0, "rd_zero");
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_zero[%0d]: got wb_valid=%b stall=%b want 0/0", k, bus.wb_valid, bus.stall);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_back_to_back();
    test_mult_exception();
    test_div_exception();
    test_timeout(1'b1, 32'd5, "div_timeout");
    test_timeout(1'b0, 32'd4, "mult_timeout");
    test_flush_wait();
    test_flush_start();
    test_flush_issue();
    test_wb_hold();
    test_reset_mid_wait();
    test_rd_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
